dma_chan_arbiter: RTL and testbench
===================================

DMA_CHAN_ARBITER -- requirements
Module: dma_chan_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, the number of requesting descriptor channels (2..8).
REQ-002 SHALL have parameter ADDR_W, default 32, the width of the source and destination addresses.
REQ-003 SHALL have parameter LEN_W, default 32, the width of the byte count.
REQ-004 clk  in  1  sole clock; all logic samples on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 ch_valid_i  in  NUM_CH  per-channel descriptor valid.
REQ-007 ch_ready_o  out  NUM_CH  per-channel descriptor accept.
REQ-008 ch_src_i / ch_dst_i  in  NUM_CH*ADDR_W each  flattened per-channel addresses; channel k uses slice [k*ADDR_W +: ADDR_W].
REQ-009 ch_len_i  in  NUM_CH*LEN_W  flattened per-channel byte counts.
REQ-010 ch_last_i  in  NUM_CH  descriptor is the final one of its chain.
REQ-011 dma_go_o  out  1  one-cycle start pulse to the DMA engine.
REQ-012 dma_src_o / dma_dst_o / dma_len_o  out  ADDR_W/ADDR_W/LEN_W  registered descriptor, held stable from go until completion.
REQ-013 dma_active_i / dma_done_i / dma_error_i  in  1 each  engine status; done and error are one-cycle pulses.
REQ-014 ch_done_o / ch_error_o  out  NUM_CH each  one-cycle per-channel IRQ pulses.
REQ-015 busy_o  out  1  asserted when the FSM is not in IDLE or a chain lock is held.
REQ-016 grant_id_o  out  $clog2(NUM_CH)  channel that owns the engine or the lock.

Function
REQ-017 The FSM SHALL use the states IDLE, ISSUE, WAIT_DONE and GAP.
REQ-018 IDLE, no lock: an eligible channel is one with ch_valid_i set; the winner is the first eligible channel scanning up from rr_ptr and wrapping modulo NUM_CH.
REQ-019 IDLE, lock held: only grant_id_o is eligible; other channels SHALL NOT be accepted even when valid.
REQ-020 ch_ready_o[g] SHALL be high only in IDLE, only for the winner g, and only while ch_valid_i[g] is high (combinational); all other bits are 0.
REQ-021 On handshake, the arbiter SHALL register the descriptor and last flag into the dma_* outputs and last_q, set grant_id_o=g, and go to ISSUE.
REQ-022 ISSUE: dma_go_o=1 for exactly one cycle, then go to WAIT_DONE; go-to-engine latency from handshake is 1 cycle.
REQ-023 WAIT_DONE: on dma_error_i, pulse ch_error_o[grant], clear the lock, set rr_ptr=grant+1 mod NUM_CH, and go to GAP.
REQ-024 WAIT_DONE: on dma_done_i without error, if last_q=1, pulse ch_done_o[grant], clear the lock, set rr_ptr=grant+1 mod NUM_CH, then go to GAP; if last_q=0, set the lock on grant, with no IRQ, then go to GAP.
REQ-025 When done_i and error_i arrive in the same cycle, error SHALL win: only ch_error_o pulses.
REQ-026 done_i and error_i outside WAIT_DONE SHALL be ignored.
REQ-027 GAP SHALL hold while dma_active_i=1, then return to IDLE one cycle after dma_active_i is low; minimum dwell is 1 cycle.
REQ-028 The dma_* descriptor outputs SHALL hold their value until the next handshake.
REQ-029 At most one ch_ready_o bit and at most one IRQ bit SHALL be set in any cycle.
REQ-030 A zero ch_len_i SHALL be forwarded unchanged; completion is whatever the engine reports.

Reset
REQ-031 While rst=1, at the next edge the block SHALL go to IDLE with rr_ptr=0, lock clear, grant_id_o=0, last_q=0, dma_*=0, dma_go_o=0, ch_ready_o=0, ch_done_o=0, ch_error_o=0 and busy_o=0.
REQ-032 Reset asserted mid-transfer SHALL abort without any IRQ; engine inputs are ignored until rst is deasserted.

Verification
REQ-033 Single channel: ch1 valid, last=1, src=0x1000, dst=0x2000, len=64 -> ready in cycle 0, go in cycle 1 with those values; done_i in cycle 5 -> ch_done_o=4'b0010 in cycle 6; rr_ptr=2.
REQ-034 Round robin: ch0 and ch2 both valid with last=1, rr_ptr=0 -> order ch0, then ch2, then ch0 again when re-requested; never two readys in one cycle.
REQ-035 Chain lock: ch0 sends 3 descriptors (last=0,0,1) while ch1 is continuously valid -> ch1 is not accepted until after ch0's third done; a single ch_done_o[0] pulse appears.
REQ-036 Error: dma_error_i and dma_done_i in the same cycle on ch3 (last=0) -> ch_error_o=4'b1000 only; lock cleared; the next grant goes to ch0.
REQ-037 GAP: dma_active_i held 3 cycles after done -> no ch_ready_o until 1 cycle after active falls.
REQ-038 Reset in WAIT_DONE -> all outputs 0 next cycle; a later done_i produces no IRQ.

Source files
------------

// File: rtl/dma_chan_arbiter_if.sv
// ---------------------------------------------------------------------------
// dma_chan_arbiter_if
//   Bundles the descriptor channels, the DMA engine handshake and the
//   per-channel IRQ lines that surround dma_chan_arbiter.
//
//   slave  : arbiter side (consumes descriptors and engine status,
//            drives ready / go / descriptor / IRQs / status)
//   master : environment side (descriptor channels plus DMA engine)
//
//   ch_valid_i / ch_ready_o      per-channel descriptor handshake
//   ch_src_i / ch_dst_i          flattened addresses, channel k at [k*ADDR_W +: ADDR_W]
//   ch_len_i                     flattened byte counts, channel k at [k*LEN_W +: LEN_W]
//   ch_last_i                    descriptor ends its chain
//   dma_go_o                     one-cycle start pulse
//   dma_src_o / dma_dst_o / dma_len_o  descriptor held for the engine
//   dma_active_i / dma_done_i / dma_error_i  engine status
//   ch_done_o / ch_error_o       one-cycle per-channel IRQ pulses
//   busy_o / grant_id_o          arbiter status
// ---------------------------------------------------------------------------
interface dma_chan_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 32
);
  logic [NUM_CH-1:0]          ch_valid_i;
  logic [NUM_CH-1:0]          ch_ready_o;
  logic [NUM_CH*ADDR_W-1:0]   ch_src_i;
  logic [NUM_CH*ADDR_W-1:0]   ch_dst_i;
  logic [NUM_CH*LEN_W-1:0]    ch_len_i;
  logic [NUM_CH-1:0]          ch_last_i;

  logic                       dma_go_o;
  logic [ADDR_W-1:0]          dma_src_o;
  logic [ADDR_W-1:0]          dma_dst_o;
  logic [LEN_W-1:0]           dma_len_o;
  logic                       dma_active_i;
  logic                       dma_done_i;
  logic                       dma_error_i;

  logic [NUM_CH-1:0]          ch_done_o;
  logic [NUM_CH-1:0]          ch_error_o;
  logic                       busy_o;
  logic [$clog2(NUM_CH)-1:0]  grant_id_o;

  modport slave (
    input  ch_valid_i, ch_src_i, ch_dst_i, ch_len_i, ch_last_i,
    input  dma_active_i, dma_done_i, dma_error_i,
    output ch_ready_o, dma_go_o, dma_src_o, dma_dst_o, dma_len_o,
    output ch_done_o, ch_error_o, busy_o, grant_id_o
  );

  modport master (
    output ch_valid_i, ch_src_i, ch_dst_i, ch_len_i, ch_last_i,
    output dma_active_i, dma_done_i, dma_error_i,
    input  ch_ready_o, dma_go_o, dma_src_o, dma_dst_o, dma_len_o,
    input  ch_done_o, ch_error_o, busy_o, grant_id_o
  );
endinterface

// File: rtl/dma_chan_arbiter.sv
// ---------------------------------------------------------------------------
// dma_chan_arbiter
//   Round-robin arbiter that hands descriptors from NUM_CH channels to a
//   single DMA engine. A channel whose descriptor is not the last of its
//   chain keeps the engine locked until its chain finishes or errors.
//
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : dma_chan_arbiter_if.slave (channels, engine, IRQs, status)
// ---------------------------------------------------------------------------
module dma_chan_arbiter #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  dma_chan_arbiter_if.slave  bus
);
  localparam int ID_W = $clog2(NUM_CH);

  typedef logic [ID_W-1:0] id_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;

  state_t             state_q, state_d;
  id_t                rr_q, grant_q, win_id, cand;
  logic               lock_q, last_q, win_found, hs;
  logic [ADDR_W-1:0]  src_q, dst_q;
  logic [LEN_W-1:0]   len_q;
  logic [NUM_CH-1:0]  done_q, error_q, ready;

  function automatic id_t next_id(input id_t id);
    return (int'(id) == NUM_CH - 1) ? '0 : id + id_t'(1);
  endfunction

  // Winner selection. Scanning offsets downwards lets the smallest offset
  // from rr_q overwrite the others, so the first eligible channel wins.
  always_comb begin
    // NOTE: every variable written here gets a default first so that no
    // path leaves it unassigned and no latch is inferred.
    win_found = 1'b0;
    win_id    = rr_q;
    cand      = '0;
    if (lock_q) begin
      win_found = bus.ch_valid_i[grant_q];
      win_id    = grant_q;
    end else begin
      for (int off = NUM_CH - 1; off >= 0; off--) begin
        cand = id_t'((int'(rr_q) + off) % NUM_CH);
        if (bus.ch_valid_i[cand]) begin
          win_found = 1'b1;
          win_id    = cand;
        end
      end
    end
  end

  // Ready is held low during reset so nothing upstream sees a handshake
  // that the registers are about to discard.
  assign hs = !rst && (state_q == IDLE) && win_found;

  always_comb begin
    ready = '0;
    if (hs) ready[win_id] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (hs) state_d = ISSUE;
      ISSUE:     state_d = WAIT_DONE;
      WAIT_DONE: if (bus.dma_error_i || bus.dma_done_i) state_d = GAP;
      GAP:       if (!bus.dma_active_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state is always updated with non-blocking
    // assignments so every flop samples the pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the descriptor registers are reset as well because they drive
      // visible outputs; there is no storage array here that could skip it.
      rr_q    <= '0;
      grant_q <= '0;
      lock_q  <= 1'b0;
      last_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      done_q  <= '0;
      error_q <= '0;
    end else begin
      done_q  <= '0;
      error_q <= '0;
      case (state_q)
        IDLE: begin
          if (hs) begin
            grant_q <= win_id;
            last_q  <= bus.ch_last_i[win_id];
            src_q   <= bus.ch_src_i[int'(win_id)*ADDR_W +: ADDR_W];
            dst_q   <= bus.ch_dst_i[int'(win_id)*ADDR_W +: ADDR_W];
            len_q   <= bus.ch_len_i[int'(win_id)*LEN_W +: LEN_W];
          end
        end
        WAIT_DONE: begin
          // Error has priority over a simultaneous done.
          if (bus.dma_error_i) begin
            error_q[grant_q] <= 1'b1;
            lock_q           <= 1'b0;
            rr_q             <= next_id(grant_q);
          end else if (bus.dma_done_i) begin
            if (last_q) begin
              done_q[grant_q] <= 1'b1;
              lock_q          <= 1'b0;
              rr_q            <= next_id(grant_q);
            end else begin
              lock_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ch_ready_o = ready;
  assign bus.dma_go_o   = (state_q == ISSUE);
  assign bus.dma_src_o  = src_q;
  assign bus.dma_dst_o  = dst_q;
  assign bus.dma_len_o  = len_q;
  assign bus.ch_done_o  = done_q;
  assign bus.ch_error_o = error_q;
  assign bus.busy_o     = (state_q != IDLE) || lock_q;
  assign bus.grant_id_o = grant_q;
endmodule

// File: tb/tb_dma_chan_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dma_chan_arbiter
//   Directed scenarios followed by randomized transfers. Expected grants come
//   from a reference arbiter (rotating pointer plus chain lock) kept as plain
//   integers; expected timing comes from the transfer timeline: go one cycle
//   after the handshake, IRQ one cycle after done/error, next grant possible
//   two cycles after the engine's active line was last high.
// ---------------------------------------------------------------------------
module tb_dma_chan_arbiter;
  localparam int NUM_CH = 4;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 32;
  localparam int ID_W   = $clog2(NUM_CH);

  logic clk = 1'b0;
  logic rst = 1'b1;

  int vectors     = 0;
  int miscompares = 0;

  // Reference arbiter state.
  int m_rr    = 0;
  bit m_lock  = 1'b0;
  int m_grant = 0;

  dma_chan_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  dma_chan_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Inputs are driven 1 time unit after the rising edge, outputs checked
  // 1 unit later, well clear of both edges.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NUM_CH-1:0] onehot(input int i);
    logic [NUM_CH-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // First valid channel counting up from the pointer, or the locked owner.
  function automatic int pick(input logic [NUM_CH-1:0] v);
    if (m_lock) return v[m_grant] ? m_grant : -1;
    for (int off = 0; off < NUM_CH; off++)
      if (v[(m_rr + off) % NUM_CH]) return (m_rr + off) % NUM_CH;
    return -1;
  endfunction

  task automatic set_desc(input int ch, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                          input logic [LEN_W-1:0] l, input bit last);
    bus.ch_src_i[ch*ADDR_W +: ADDR_W] = s;
    bus.ch_dst_i[ch*ADDR_W +: ADDR_W] = d;
    bus.ch_len_i[ch*LEN_W +: LEN_W]   = l;
    bus.ch_last_i[ch]                 = last;
    bus.ch_valid_i[ch]                = 1'b1;
  endtask

  task automatic rand_desc(input int ch);
    logic [LEN_W-1:0] l;
    l = ($urandom_range(0, 4) == 0) ? '0 : LEN_W'($urandom);
    set_desc(ch, $urandom, $urandom, l, $urandom_range(0, 2) != 0);
  endtask

  task automatic apply_reset();
    rst              = 1'b1;
    bus.ch_valid_i   = '0;
    bus.dma_done_i   = 1'b0;
    bus.dma_error_i  = 1'b0;
    bus.dma_active_i = 1'b0;
    cyc();
    rst     = 1'b0;
    m_rr    = 0;
    m_lock  = 1'b0;
    m_grant = 0;
  endtask

  // One full transfer starting in an idle cycle: handshake, go, `dly` wait
  // cycles, done/error, IRQ, `extra` cycles of active in the gap, then the
  // first cycle in which the next handshake is allowed.
  task automatic run_xfer(input int exp_g, input int dly, input bit err, input bit done_too,
                          input int extra, input bit spur,
                          input logic [NUM_CH-1:0] exp_done, input logic [NUM_CH-1:0] exp_err);
    logic [ADDR_W-1:0] s, d;
    logic [LEN_W-1:0]  l;
    bit                lock_exp;
    lock_exp = (exp_done == '0) && (exp_err == '0);
    #1;
    vectors++;
    if (bus.ch_ready_o !== onehot(exp_g)) begin
      miscompares++;
      $display("FAIL grant_ready: got %b, expected %b", bus.ch_ready_o, onehot(exp_g));
    end
    s = bus.ch_src_i[exp_g*ADDR_W +: ADDR_W];
    d = bus.ch_dst_i[exp_g*ADDR_W +: ADDR_W];
    l = bus.ch_len_i[exp_g*LEN_W +: LEN_W];

    cyc();
    bus.ch_valid_i[exp_g] = 1'b0;
    bus.dma_active_i      = 1'b1;
    #1;
    vectors++;
    if ({bus.dma_go_o, bus.dma_src_o, bus.dma_dst_o, bus.dma_len_o, bus.grant_id_o, bus.busy_o} !==
        {1'b1, s, d, l, ID_W'(exp_g), 1'b1}) begin
      miscompares++;
      $display("FAIL go_desc: got go=%b src=%h dst=%h len=%h grant=%0d busy=%b, expected go=1 src=%h dst=%h len=%h grant=%0d busy=1",
               bus.dma_go_o, bus.dma_src_o, bus.dma_dst_o, bus.dma_len_o, bus.grant_id_o, bus.busy_o,
               s, d, l, exp_g);
    end
    vectors++;
    if ({bus.ch_ready_o, bus.ch_done_o, bus.ch_error_o} !== '0) begin
      miscompares++;
      $display("FAIL go_quiet: got ready=%b done=%b err=%b, expected all 0",
               bus.ch_ready_o, bus.ch_done_o, bus.ch_error_o);
    end

    for (int i = 0; i < dly; i++) begin
      cyc();
      #1;
      vectors++;
      if ({bus.dma_go_o, bus.ch_ready_o, bus.ch_done_o, bus.ch_error_o} !== '0) begin
        miscompares++;
        $display("FAIL wait_quiet: got go=%b ready=%b done=%b err=%b, expected all 0",
                 bus.dma_go_o, bus.ch_ready_o, bus.ch_done_o, bus.ch_error_o);
      end
    end

    cyc();
    bus.dma_done_i  = done_too || !err;
    bus.dma_error_i = err;
    #1;
    vectors++;
    if ({bus.dma_go_o, bus.ch_ready_o, bus.ch_done_o, bus.ch_error_o} !== '0) begin
      miscompares++;
      $display("FAIL done_cycle: got go=%b ready=%b done=%b err=%b, expected all 0",
               bus.dma_go_o, bus.ch_ready_o, bus.ch_done_o, bus.ch_error_o);
    end

    cyc();
    bus.dma_done_i   = 1'b0;
    bus.dma_error_i  = 1'b0;
    bus.dma_active_i = (extra > 0);
    #1;
    vectors++;
    if ({bus.ch_done_o, bus.ch_error_o, bus.ch_ready_o} !== {exp_done, exp_err, {NUM_CH{1'b0}}}) begin
      miscompares++;
      $display("FAIL irq: got done=%b err=%b ready=%b, expected done=%b err=%b ready=0",
               bus.ch_done_o, bus.ch_error_o, bus.ch_ready_o, exp_done, exp_err);
    end

    for (int i = 1; i <= extra; i++) begin
      cyc();
      bus.dma_active_i = (i < extra);
      bus.dma_done_i   = spur && (i == 1);
      bus.dma_error_i  = spur && (i == 1);
      #1;
      vectors++;
      if ({bus.ch_ready_o, bus.ch_done_o, bus.ch_error_o, bus.busy_o} !== {{(3*NUM_CH){1'b0}}, 1'b1}) begin
        miscompares++;
        $display("FAIL gap_hold: got ready=%b done=%b err=%b busy=%b, expected ready=0 done=0 err=0 busy=1",
                 bus.ch_ready_o, bus.ch_done_o, bus.ch_error_o, bus.busy_o);
      end
    end

    cyc();
    bus.dma_done_i  = 1'b0;
    bus.dma_error_i = 1'b0;
    #1;
    vectors++;
    if ({bus.ch_done_o, bus.ch_error_o, bus.dma_src_o, bus.dma_dst_o, bus.dma_len_o, bus.busy_o} !==
        {{(2*NUM_CH){1'b0}}, s, d, l, lock_exp}) begin
      miscompares++;
      $display("FAIL idle_after_gap: got done=%b err=%b src=%h dst=%h len=%h busy=%b, expected done=0 err=0 src=%h dst=%h len=%h busy=%b",
               bus.ch_done_o, bus.ch_error_o, bus.dma_src_o, bus.dma_dst_o, bus.dma_len_o, bus.busy_o,
               s, d, l, lock_exp);
    end
  endtask

  task automatic test_reset();
    rst              = 1'b1;
    bus.ch_valid_i   = '1;
    bus.dma_done_i   = 1'b1;
    bus.dma_error_i  = 1'b1;
    bus.dma_active_i = 1'b1;
    for (int c = 0; c < NUM_CH; c++) rand_desc(c);
    for (int k = 0; k < 2; k++) begin
      cyc();
      #1;
      vectors++;
      if ({bus.ch_ready_o, bus.dma_go_o, bus.dma_src_o, bus.dma_dst_o, bus.dma_len_o,
           bus.ch_done_o, bus.ch_error_o, bus.busy_o, bus.grant_id_o} !== '0) begin
        miscompares++;
        $display("FAIL reset_state: got ready=%b go=%b src=%h dst=%h len=%h done=%b err=%b busy=%b grant=%0d, expected all 0",
                 bus.ch_ready_o, bus.dma_go_o, bus.dma_src_o, bus.dma_dst_o, bus.dma_len_o,
                 bus.ch_done_o, bus.ch_error_o, bus.busy_o, bus.grant_id_o);
      end
    end
    apply_reset();
    #1;
    vectors++;
    if ({bus.ch_ready_o, bus.busy_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_release: got ready=%b busy=%b, expected 0 0", bus.ch_ready_o, bus.busy_o);
    end
  endtask

  task automatic test_single();
    apply_reset();
    set_desc(1, 32'h1000, 32'h2000, 32'd64, 1'b1);
    run_xfer(1, 3, 1'b0, 1'b0, 0, 1'b0, 4'b0010, 4'b0000);
    // Pointer now 2: with ch0..ch2 valid the order is 2, 0, 1.
    set_desc(0, 32'hA0, 32'hB0, 32'd4, 1'b1);
    set_desc(1, 32'hA1, 32'hB1, 32'd8, 1'b1);
    set_desc(2, 32'hA2, 32'hB2, 32'd0, 1'b1);
    run_xfer(2, 0, 1'b0, 1'b0, 0, 1'b0, 4'b0100, 4'b0000);
    run_xfer(0, 1, 1'b0, 1'b0, 1, 1'b0, 4'b0001, 4'b0000);
    run_xfer(1, 0, 1'b0, 1'b0, 0, 1'b0, 4'b0010, 4'b0000);
  endtask

  task automatic test_round_robin();
    apply_reset();
    set_desc(0, 32'h100, 32'h200, 32'd16, 1'b1);
    set_desc(2, 32'h300, 32'h400, 32'd32, 1'b1);
    run_xfer(0, 1, 1'b0, 1'b0, 0, 1'b0, 4'b0001, 4'b0000);
    set_desc(0, 32'h500, 32'h600, 32'd48, 1'b1);
    run_xfer(2, 2, 1'b0, 1'b0, 0, 1'b0, 4'b0100, 4'b0000);
    set_desc(2, 32'h700, 32'h800, 32'd80, 1'b1);
    run_xfer(0, 0, 1'b0, 1'b0, 0, 1'b0, 4'b0001, 4'b0000);
    run_xfer(2, 0, 1'b0, 1'b0, 0, 1'b0, 4'b0100, 4'b0000);
  endtask

  task automatic test_chain_lock();
    apply_reset();
    set_desc(1, 32'h1111, 32'h2222, 32'd12, 1'b1);
    for (int n = 0; n < 3; n++) begin
      set_desc(0, 32'h4000 + n, 32'h8000 + n, 32'd100 + n, n == 2);
      run_xfer(0, n, 1'b0, 1'b0, n, 1'b0, (n == 2) ? 4'b0001 : 4'b0000, 4'b0000);
      if (n < 2) begin
        for (int k = 0; k < 2; k++) begin
          vectors++;
          if ({bus.ch_ready_o, bus.busy_o, bus.grant_id_o} !== {4'b0000, 1'b1, ID_W'(0)}) begin
            miscompares++;
            $display("FAIL lock_hold: got ready=%b busy=%b grant=%0d, expected ready=0000 busy=1 grant=0",
                     bus.ch_ready_o, bus.busy_o, bus.grant_id_o);
          end
          cyc();
          #1;
        end
      end
    end
    run_xfer(1, 0, 1'b0, 1'b0, 0, 1'b0, 4'b0010, 4'b0000);
  endtask

  task automatic test_error();
    apply_reset();
    set_desc(3, 32'hDEAD, 32'hBEEF, 32'd7, 1'b0);
    run_xfer(3, 2, 1'b1, 1'b1, 0, 1'b0, 4'b0000, 4'b1000);
    set_desc(0, 32'hC0, 32'hD0, 32'd1, 1'b1);
    set_desc(1, 32'hC1, 32'hD1, 32'd2, 1'b1);
    set_desc(3, 32'hC3, 32'hD3, 32'd3, 1'b1);
    run_xfer(0, 0, 1'b0, 1'b0, 0, 1'b0, 4'b0001, 4'b0000);
  endtask

  task automatic test_gap();
    apply_reset();
    set_desc(1, 32'h10, 32'h20, 32'd0, 1'b1);
    set_desc(2, 32'h30, 32'h40, 32'd9, 1'b1);
    run_xfer(1, 1, 1'b0, 1'b0, 3, 1'b1, 4'b0010, 4'b0000);
    run_xfer(2, 0, 1'b0, 1'b0, 0, 1'b0, 4'b0100, 4'b0000);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_desc(2, 32'h55, 32'h66, 32'h10, 1'b1);
    #1;
    vectors++;
    if (bus.ch_ready_o !== 4'b0100) begin
      miscompares++;
      $display("FAIL midrst_ready: got %b, expected 0100", bus.ch_ready_o);
    end
    cyc();
    bus.ch_valid_i   = '0;
    bus.dma_active_i = 1'b1;
    cyc();
    // In WAIT_DONE: reset and done arrive together.
    rst            = 1'b1;
    bus.dma_done_i = 1'b1;
    cyc();
    #1;
    vectors++;
    if ({bus.ch_ready_o, bus.dma_go_o, bus.dma_src_o, bus.dma_dst_o, bus.dma_len_o,
         bus.ch_done_o, bus.ch_error_o, bus.busy_o, bus.grant_id_o} !== '0) begin
      miscompares++;
      $display("FAIL midrst_clear: got ready=%b go=%b src=%h dst=%h len=%h done=%b err=%b busy=%b grant=%0d, expected all 0",
               bus.ch_ready_o, bus.dma_go_o, bus.dma_src_o, bus.dma_dst_o, bus.dma_len_o,
               bus.ch_done_o, bus.ch_error_o, bus.busy_o, bus.grant_id_o);
    end
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      bus.dma_done_i = (k == 0);
      #1;
      vectors++;
      if ({bus.ch_done_o, bus.ch_error_o, bus.busy_o} !== '0) begin
        miscompares++;
        $display("FAIL midrst_no_irq: got done=%b err=%b busy=%b, expected all 0",
                 bus.ch_done_o, bus.ch_error_o, bus.busy_o);
      end
    end
    bus.dma_done_i   = 1'b0;
    bus.dma_active_i = 1'b0;
  endtask

  task automatic gen_requests(input bit force_one);
    int c;
    for (int k = 0; k < NUM_CH; k++)
      if (!bus.ch_valid_i[k] && $urandom_range(0, 2) == 0) rand_desc(k);
    if (force_one) begin
      c = m_lock ? m_grant : int'($urandom_range(0, NUM_CH - 1));
      if (!bus.ch_valid_i[c]) rand_desc(c);
    end
  endtask

  task automatic test_random(input int n_xfers);
    int g, tries;
    bit err, last;
    logic [NUM_CH-1:0] exp_done, exp_err;
    apply_reset();
    for (int t = 0; t < n_xfers; t++) begin
      tries = 0;
      gen_requests(1'b0);
      g = pick(bus.ch_valid_i);
      while (g < 0) begin
        #1;
        vectors++;
        if ({bus.ch_ready_o, bus.busy_o} !== {{NUM_CH{1'b0}}, m_lock}) begin
          miscompares++;
          $display("FAIL rand_no_winner: got ready=%b busy=%b, expected ready=0 busy=%b",
                   bus.ch_ready_o, bus.busy_o, m_lock);
        end
        cyc();
        tries++;
        gen_requests(tries >= 3);
        g = pick(bus.ch_valid_i);
      end
      last     = bus.ch_last_i[g];
      err      = ($urandom_range(0, 3) == 0);
      exp_done = (!err && last) ? onehot(g) : '0;
      exp_err  = err ? onehot(g) : '0;
      run_xfer(g, $urandom_range(0, 4), err, $urandom_range(0, 1) == 1, $urandom_range(0, 3),
               $urandom_range(0, 1) == 1, exp_done, exp_err);
      if (err || last) begin
        m_lock = 1'b0;
        m_rr   = (g + 1) % NUM_CH;
      end else begin
        m_lock  = 1'b1;
        m_grant = g;
      end
    end
  endtask

  initial begin
    bus.ch_valid_i   = '0;
    bus.ch_src_i     = '0;
    bus.ch_dst_i     = '0;
    bus.ch_len_i     = '0;
    bus.ch_last_i    = '0;
    bus.dma_done_i   = 1'b0;
    bus.dma_error_i  = 1'b0;
    bus.dma_active_i = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_chain_lock();
    test_error();
    test_gap();
    test_reset_mid();
    test_random(60);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1, "timeout");
  end
endmodule
